// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, state numbers,
// datapath select codes and the packed control word driven every cycle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  // States whose exit back to FETCH completes (retires) an instruction.
  function automatic logic is_retire_state(input state_t s);
    case (s)
      ST_MEM_WB, ST_MEM_WRITE, ST_R_WB,
      ST_BRANCH, ST_JUMP, ST_ADDI_WB: is_retire_state = 1'b1;
      default:                        is_retire_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_despacho.sv
// Dispatch decoder: maps the opcode seen in DECODE to the state that follows it.
// Anything not in the supported set is routed to TRAP.
module decodificador_despacho
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output state_t     next_state
);

  always_comb begin
    next_state = ST_TRAP;
    case (op)
      OP_LW, OP_SW: next_state = ST_MEM_ADDR;
      OP_RTYPE:     next_state = ST_EXECUTE;
      OP_BEQ:       next_state = ST_BRANCH;
      OP_J:         next_state = ST_JUMP;
      OP_ADDI:      next_state = ST_ADDI_EX;
      default:      next_state = ST_TRAP;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control FSM: Moore-decoded datapath strobes, memory-ready
// stalls, sticky trap on unsupported opcodes and a retired-instruction counter.
module unidad_control_multiciclo
  import mips_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  Op,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        Trap,
  output logic [3:0]  Estado,
  output logic [31:0] InstrCount
);

  state_t      state_reg;
  state_t      state_next;
  state_t      dispatch_state;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;
  logic [31:0] instr_count_reg;
  logic        retire;

  // The branch decision is taken in the datapath (PCWriteCond & Zero), so the
  // zero flag is only carried through this block.
  logic        unused_zero;
  assign unused_zero = Zero;

  decodificador_despacho u_despacho (
    .op         (Op),
    .next_state (dispatch_state)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= ST_FETCH;
      instr_count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (retire)
        instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl       = '0;
    case (state_reg)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = MemReady;
        ctrl.pc_write  = MemReady;
        if (MemReady)
          state_next = ST_DECODE;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        state_next     = dispatch_state;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_next     = (Op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (MemReady)
          state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_next      = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (MemReady)
          state_next = ST_FETCH;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = ST_R_WB;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_next         = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_next     = ST_FETCH;
      end
      ST_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_next     = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: begin
        state_next = ST_TRAP;
      end
    endcase
  end

  // Reset blanks every strobe so no PC/IR/register write slips out while held.
  assign ctrl_out = RST ? '0 : ctrl;
  assign retire   = !RST && (state_next == ST_FETCH) && is_retire_state(state_reg);

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.i_or_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemToReg    = ctrl_out.mem_to_reg;
  assign RegWrite    = ctrl_out.reg_write;
  assign RegDst      = ctrl_out.reg_dst;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;
  assign Trap        = ctrl_out.trap;
  assign Estado      = state_reg;
  assign InstrCount  = instr_count_reg;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench: per-instruction phase traces built from opcode rules,
// random memory stalls and opcode noise, plus directed trap/reset/wrap cases.
module tb_unidad_control_multiciclo;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  Op = 6'h00;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegWrite, RegDst, ALUSrcA, Trap;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  Estado;
  logic [31:0] InstrCount;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_count = 32'd0;

  always #5 CLK = ~CLK;

  unidad_control_multiciclo dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Trap(Trap), .Estado(Estado), .InstrCount(InstrCount)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegWrite,
  //  RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,Trap}
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr);
    logic [16:0] v;
    v = '0;
    case (st)
      0:  v = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b0};
      1:  v = {10'b0, 2'b11, 2'b00, 2'b00, 1'b0};
      2:  v = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      3:  v = {2'b00, 1'b1, 1'b1, 6'b0, 7'b0};
      4:  v = {6'b0, 1'b1, 1'b1, 2'b00, 7'b0};
      5:  v = {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 7'b0};
      6:  v = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
      7:  v = {7'b0, 1'b1, 1'b1, 1'b0, 7'b0};
      8:  v = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
      9:  v = {1'b1, 9'b0, 2'b00, 2'b00, 2'b10, 1'b0};
      10: v = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      11: v = {7'b0, 1'b1, 2'b00, 7'b0};
      12: v = {16'b0, 1'b1};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit supported(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later.
  task automatic step(input int st, input logic mr, input logic [5:0] op, input logic rst);
    logic [16:0] obs;
    @(negedge CLK);
    RST      = rst;
    MemReady = mr;
    Op       = (st == 1 || st == 2) ? op : 6'($urandom);
    #1;
    obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap};
    check($sformatf("estado(st%0d)", st), 32'(Estado), 32'(st));
    check($sformatf("ctrl(st%0d,mr%0d,rst%0d)", st, mr, rst), 32'(obs),
          rst ? 32'd0 : 32'(exp_ctrl(st, mr)));
    check($sformatf("count(st%0d)", st), InstrCount, model_count);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int trap_cycles, input bit preload);
    int st_q[$];
    bit mr_q[$];
    for (int k = 0; k < fw; k++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      6'h00: begin st_q.push_back(6); st_q.push_back(7); end
      6'h23: begin
        st_q.push_back(2);
        for (int k = 0; k < mw; k++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4);
      end
      6'h2B: begin
        st_q.push_back(2);
        for (int k = 0; k < mw; k++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      6'h04: st_q.push_back(8);
      6'h02: st_q.push_back(9);
      6'h08: begin st_q.push_back(10); st_q.push_back(11); end
      default: for (int k = 0; k < trap_cycles; k++) st_q.push_back(12);
    endcase
    // mr_q only pins the memory-wait cycles; elsewhere MemReady is noise.
    for (int i = 0, m = 0; i < st_q.size(); i++) begin
      bit mr;
      if (st_q[i] == 0 || st_q[i] == 3 || st_q[i] == 5) begin
        mr = mr_q[m]; m++;
      end else begin
        if (st_q[i] == 1) m++;
        mr = 1'($urandom);
      end
      step(st_q[i], mr, op, 1'b0);
      if (preload && i == 0) begin
        force dut.instr_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_reg;
        model_count = 32'hFFFF_FFFF;
      end
    end
    if (supported(op)) model_count = model_count + 32'd1;
    $display("instr op=%h fetch_waits=%0d mem_waits=%0d cycles=%0d count=%h",
             op, fw, mw, st_q.size(), model_count);
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    RST = 1'b1;
    MemReady = 1'b1;
    repeat (2) @(posedge CLK);
    step(0, 1'b1, 6'h00, 1'b1);

    run_instr(6'h00, 0, 0, 0, 1'b0);
    run_instr(6'h23, 0, 3, 0, 1'b0);
    run_instr(6'h04, 0, 0, 0, 1'b0);
    run_instr(6'h02, 0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 0, 1'b0);

    run_instr(6'h2B, 1, 1, 0, 1'b1);
    run_instr(6'h08, 0, 0, 0, 1'b0);

    run_instr(6'h3F, 0, 0, 12, 1'b0);
    step(12, 1'b1, 6'h00, 1'b1);
    model_count = 32'd0;
    step(0, 1'b1, 6'h00, 1'b1);
    $display("reset out of trap count=%h", model_count);

    run_instr(6'h02, 0, 0, 0, 1'b0);

    step(0, 1'b1, 6'h2B, 1'b0);
    step(1, 1'b1, 6'h2B, 1'b0);
    step(2, 1'b1, 6'h2B, 1'b0);
    step(5, 1'b0, 6'h2B, 1'b0);
    step(5, 1'b0, 6'h2B, 1'b1);
    model_count = 32'd0;
    step(0, 1'b1, 6'h2B, 1'b1);
    $display("reset inside sw memory wait count=%h", model_count);

    run_instr(6'h00, 0, 0, 0, 1'b0);
    step(0, 1'b0, 6'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Multicycle control FSM that sequences the team's MIPS datapath over a shared instruction/data memory, replacing the single-cycle control unit. It decodes the opcode once per instruction and drives every datapath select and strobe state by state. It stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions. It sits beside the datapath and connects to the IR opcode field, the ALU zero flag and the memory ready line.

## Interface
- No parameters.
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- Op  in  6  opcode, IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath strobes/selects
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- Trap  out  1  sticky unsupported-opcode flag
- Estado  out  4  current state, debug
- InstrCount  out  32  retired-instruction counter

## Operation
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- Outputs are decoded from state (Moore). IRWrite and PCWrite in FETCH are additionally gated by MemReady. Every output not listed for a state is 0.
- FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Stays in FETCH until MemReady, then -> DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op: lw/sw -> MEM_ADDR; R -> EXECUTE; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX; any other -> TRAP.
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ(3): MemRead, IorD=1. Holds until MemReady, then -> MEM_WB.
- MEM_WB(4): RegWrite, MemToReg=1, RegDst=0. -> FETCH.
- MEM_WRITE(5): MemWrite, IorD=1. Holds until MemReady, then -> FETCH.
- EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> R_WB.
- R_WB(7): RegWrite, RegDst=1, MemToReg=0. -> FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. -> FETCH.
- JUMP(9): PCWrite, PCSource=10. -> FETCH.
- ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
- ADDI_WB(11): RegWrite, RegDst=0, MemToReg=0. -> FETCH.
- TRAP(12): all strobes 0, Trap=1. Stays in TRAP until RST.
- InstrCount increments by 1 on every transition into FETCH from states 4, 5, 7, 8, 9 and 11.
- InstrCount wraps from 0xFFFFFFFF to 0.
- Unused encodings 13–15 -> TRAP on the next edge.

## Timing
- RST sampled at a rising edge:
  - state -> FETCH, InstrCount -> 0, Trap -> 0.
  - While RST is high, all strobes are forced to 0, so no PC, IR or register writes occur even though the state is FETCH.
- RST mid-instruction, including inside a memory wait: the instruction is abandoned and is not counted.
- Latency with MemReady=1 continuously, measured from FETCH entry to the next FETCH entry:
  - 3 cycles: beq, j
  - 4 cycles: R-type, sw, addi
  - 5 cycles: lw
- Each cycle MemReady is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. MemRead/MemWrite and IorD stay stable for the whole wait.
- MemReady is ignored in all other states.
- Op is sampled only in DECODE and MEM_ADDR. Changes to Op while in other states have no effect.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - the 4-bit state encodings listed above
  - ALUOp, ALUSrcB and PCSource encodings
- The single-cycle control unit is not modified.
- One sub-module, decodificador_despacho: combinational mapping of Op to the DECODE successor state, including the TRAP default.

## Test plan
- RST high 2 cycles, then low; R-type Op=0x00, MemReady=1 -> states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. InstrCount=1.
- lw Op=0x23, MemReady low for 3 cycles in MEM_READ -> 8 cycles total. MemRead=1 and IorD=1 held for 4 cycles. MemToReg=1 in MEM_WB.
- beq Op=0x04 -> PCWriteCond=1, ALUOp=01, PCSource=01 for exactly one cycle. PCWrite=0 throughout state 8. 3-cycle instruction.
- j Op=0x02, then Op=0x3F -> j takes 3 cycles with PCSource=10. The next instruction enters TRAP: Trap=1, all strobes 0 for 10+ cycles. InstrCount stays 1.
- Preload InstrCount to 0xFFFFFFFF via 2^32 retirements (or force), then sw Op=0x2B -> InstrCount=0.
- RST asserted in MEM_WRITE with MemReady=0 -> next cycle in FETCH. MemWrite=0 and no count increment. PCWrite=IRWrite=0 while RST high.
